// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch front end with req/gnt memory port,
// prefetch FIFO and the F->D pipeline register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall_d,
  input  logic        Flush_d,
  input  logic        PCSrc_e,
  input  logic [31:0] PCTarget_e,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_d,
  output logic [31:0] PC_d,
  output logic [31:0] PCPlus4_d,
  output logic        Valid_d
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_fetch_pc, r_rsp_pc;
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
  logic [CW-1:0] r_wptr, r_rptr, r_outstanding, r_drop_cnt;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_inflight;
  logic          w_pop, w_fire, w_push, w_drop;

  assign w_count    = r_wptr - r_rptr;
  assign w_pop      = !Flush_d && !Stall_d && (w_count != '0);
  // a slot freed by this cycle's pop may be refilled by this cycle's request
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_count} - (CW+1)'(w_pop);
  assign imem_req   = rst_n && !PCSrc_e && (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign imem_addr  = r_fetch_pc;
  assign w_fire     = imem_req && imem_gnt;
  assign w_drop     = imem_rvalid && (r_drop_cnt != '0);
  assign w_push     = imem_rvalid && (r_drop_cnt == '0) && !PCSrc_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_fire) - CW'(imem_rvalid);
      if (PCSrc_e) begin
        r_fetch_pc <= PCTarget_e;
        r_rsp_pc   <= PCTarget_e;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_drop_cnt <= r_outstanding - CW'(imem_rvalid);
      end else begin
        r_fetch_pc <= w_fire ? r_fetch_pc + 32'd4 : r_fetch_pc;
        r_rsp_pc   <= w_push ? r_rsp_pc + 32'd4 : r_rsp_pc;
        r_wptr     <= r_wptr + CW'(w_push);
        r_rptr     <= r_rptr + CW'(w_pop);
        r_drop_cnt <= r_drop_cnt - CW'(w_drop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wptr[AW-1:0]] <= imem_rdata;
      r_fifo_pc[r_wptr[AW-1:0]]    <= r_rsp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Instr_d   <= NOP;
      PC_d      <= '0;
      PCPlus4_d <= '0;
      Valid_d   <= 1'b0;
    end else if (Flush_d) begin
      Instr_d <= NOP;
      Valid_d <= 1'b0;
    end else if (!Stall_d) begin
      if (w_pop) begin
        Instr_d   <= r_fifo_instr[r_rptr[AW-1:0]];
        PC_d      <= r_fifo_pc[r_rptr[AW-1:0]];
        PCPlus4_d <= r_fifo_pc[r_rptr[AW-1:0]] + 32'd4;
        Valid_d   <= 1'b1;
      end else begin
        Instr_d <= NOP;
        Valid_d <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit; a memory model with variable
// latency feeds the DUT and a program-stream model predicts the D register.
module tb_fetch_unit;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Stall_d = 1'b0, Flush_d = 1'b0, PCSrc_e = 1'b0;
  logic [31:0] PCTarget_e = '0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] Instr_d, PC_d, PCPlus4_d;
  logic        Valid_d;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .Stall_d(Stall_d), .Flush_d(Flush_d),
    .PCSrc_e(PCSrc_e), .PCTarget_e(PCTarget_e), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .Instr_d(Instr_d), .PC_d(PC_d),
    .PCPlus4_d(PCPlus4_d), .Valid_d(Valid_d)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; int ep; } mreq_t;
  typedef struct { logic [31:0] pc; int rdy; } av_t;
  mreq_t mq[$];
  av_t   avq[$];

  int n_chk = 0, n_fail = 0, cyc = 0, lat = 1, epoch = 0, n_grants = 0, first_grant = -1;
  logic        exp_valid;
  logic [31:0] exp_instr, exp_pc, exp_pc4, exp_fetch;

  task automatic model_reset();
    mq.delete();
    avq.delete();
    epoch++;
    exp_valid = 1'b0; exp_instr = NOP; exp_pc = '0; exp_pc4 = '0; exp_fetch = 32'h0;
  endtask

  // One clock cycle: memory response, grant capture, stream model, D check.
  task automatic tick();
    mreq_t mr;
    av_t   av;
    logic  rv;
    int    due;
    rv = 1'b0;
    mr = '{32'h0, 0, 0};
    if (mq.size() > 0 && mq[0].due <= cyc) begin mr = mq.pop_front(); rv = 1'b1; end
    imem_rvalid = rv;
    imem_rdata  = rv ? (mr.addr ^ KEY) : $urandom;
    #1;
    if (PCSrc_e) begin
      n_chk++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redirect_no_req: imem_req=%b want 0", imem_req); end
    end
    if (imem_req && imem_gnt) begin
      n_chk++;
      if (imem_addr !== exp_fetch) begin n_fail++; $display("FAIL grant_addr: got %h want %h", imem_addr, exp_fetch); end
      due = cyc + lat;
      if (mq.size() > 0 && due <= mq[$].due) due = mq[$].due + 1;
      mq.push_back('{exp_fetch, due, epoch});
      exp_fetch += 32'd4;
      n_grants++;
      if (first_grant < 0) first_grant = cyc;
    end
    if (Flush_d) begin
      exp_valid = 1'b0; exp_instr = NOP;
    end else if (!Stall_d) begin
      if (avq.size() > 0 && avq[0].rdy <= cyc) begin
        av = avq.pop_front();
        exp_valid = 1'b1; exp_pc = av.pc; exp_pc4 = av.pc + 32'd4; exp_instr = av.pc ^ KEY;
      end else begin
        exp_valid = 1'b0; exp_instr = NOP;
      end
    end
    if (rv && mr.ep == epoch) avq.push_back('{mr.addr, cyc + 1});
    if (PCSrc_e) begin avq.delete(); epoch++; exp_fetch = PCTarget_e; end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    n_chk += 4;
    if (Valid_d !== exp_valid) begin n_fail++; $display("FAIL model_valid @%0d: got %b want %b", cyc, Valid_d, exp_valid); end
    if (Instr_d !== exp_instr) begin n_fail++; $display("FAIL model_instr @%0d: got %h want %h", cyc, Instr_d, exp_instr); end
    if (PC_d !== exp_pc) begin n_fail++; $display("FAIL model_pc @%0d: got %h want %h", cyc, PC_d, exp_pc); end
    if (PCPlus4_d !== exp_pc4) begin n_fail++; $display("FAIL model_pc4 @%0d: got %h want %h", cyc, PCPlus4_d, exp_pc4); end
  endtask

  task automatic drain();
    imem_gnt = 1'b0; Stall_d = 1'b0; Flush_d = 1'b0; PCSrc_e = 1'b0;
    for (int i = 0; i < 20 && mq.size() > 0; i++) tick();
    repeat (6) tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    n_chk += 5;
    if (Valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", Valid_d); end
    if (Instr_d !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", Instr_d, NOP); end
    if (PC_d !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", PC_d); end
    if (PCPlus4_d !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h want 0", PCPlus4_d); end
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    int v;
    v = -1;
    imem_gnt = 1'b1; lat = 1; first_grant = -1;
    for (int i = 0; i < 20 && v < 0; i++) begin
      tick();
      if (Valid_d === 1'b1) v = cyc;
    end
    n_chk += 2;
    if (first_grant < 0 || v != first_grant + 3) begin n_fail++; $display("FAIL first_latency: valid at %0d grant at %0d want +3", v, first_grant); end
    if (PC_d !== 32'h0) begin n_fail++; $display("FAIL first_pc: got %h want 0", PC_d); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_chk += 2;
      if (Valid_d !== 1'b1 || PC_d !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_pc: got %b/%h want 1/%h", Valid_d, PC_d, 32'(4 * k)); end
      if (Instr_d !== (32'(4 * k) ^ KEY)) begin n_fail++; $display("FAIL stream_instr: got %h want %h", Instr_d, 32'(4 * k) ^ KEY); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] frozen;
    frozen = exp_pc;
    Stall_d = 1'b1;
    repeat (6) begin
      tick();
      n_chk++;
      if (Valid_d !== 1'b1 || PC_d !== frozen) begin n_fail++; $display("FAIL stall_hold: got %b/%h want 1/%h", Valid_d, PC_d, frozen); end
    end
    #1;
    n_chk++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_full_req: got %b want 0", imem_req); end
    Stall_d = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_chk++;
      if (Valid_d !== 1'b1 || PC_d !== frozen + 32'(4 * k)) begin n_fail++; $display("FAIL stall_resume: got %b/%h want 1/%h", Valid_d, PC_d, frozen + 32'(4 * k)); end
    end
  endtask

  task automatic test_redirect();
    int found;
    lat = 3;
    drain();
    imem_gnt = 1'b1;
    repeat (2) tick();
    imem_gnt = 1'b0;
    n_chk++;
    if (mq.size() != 2) begin n_fail++; $display("FAIL redirect_setup: outstanding %0d want 2", mq.size()); end
    PCSrc_e = 1'b1; Flush_d = 1'b1; PCTarget_e = 32'h100;
    tick();
    n_chk++;
    if (Valid_d !== 1'b0 || Instr_d !== NOP) begin n_fail++; $display("FAIL redirect_bubble: got %b/%h want 0/%h", Valid_d, Instr_d, NOP); end
    PCSrc_e = 1'b0; Flush_d = 1'b0; imem_gnt = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (Valid_d === 1'b1) found = 1;
    end
    n_chk += 2;
    if (!found || PC_d !== 32'h100) begin n_fail++; $display("FAIL redirect_pc: got %h want 00000100", PC_d); end
    if (PCPlus4_d !== 32'h104 || Instr_d !== (32'h100 ^ KEY)) begin n_fail++; $display("FAIL redirect_pc4: got %h/%h want 00000104/%h", PCPlus4_d, Instr_d, 32'h100 ^ KEY); end
    lat = 1;
  endtask

  task automatic test_gnt_hold();
    logic [31:0] a0;
    lat = 1;
    drain();
    a0 = exp_fetch;
    repeat (4) begin
      #1;
      n_chk++;
      if (imem_req !== 1'b1 || imem_addr !== a0) begin n_fail++; $display("FAIL gnt_hold: got %b/%h want 1/%h", imem_req, imem_addr, a0); end
      tick();
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    #1;
    n_chk++;
    if (imem_addr !== a0 + 32'd4) begin n_fail++; $display("FAIL gnt_single: got %h want %h", imem_addr, a0 + 32'd4); end
    tick();
    n_chk++;
    if (imem_addr !== a0 + 32'd4) begin n_fail++; $display("FAIL gnt_after: got %h want %h", imem_addr, a0 + 32'd4); end
  endtask

  task automatic test_flush_stall();
    logic [31:0] head;
    imem_gnt = 1'b1; lat = 1;
    Stall_d = 1'b1;
    repeat (6) tick();
    head = (avq.size() > 0) ? avq[0].pc : 32'hFFFF_FFFF;
    Flush_d = 1'b1;
    tick();
    n_chk++;
    if (Valid_d !== 1'b0 || Instr_d !== NOP) begin n_fail++; $display("FAIL flush_stall: got %b/%h want 0/%h", Valid_d, Instr_d, NOP); end
    Flush_d = 1'b0; Stall_d = 1'b0;
    tick();
    n_chk++;
    if (Valid_d !== 1'b1 || PC_d !== head) begin n_fail++; $display("FAIL flush_stall_keep: got %b/%h want 1/%h", Valid_d, PC_d, head); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Stall_d  = ($urandom % 4) == 0;
      Flush_d  = ($urandom % 10) == 0;
      imem_gnt = ($urandom % 10) < 7;
      lat      = 1 + int'($urandom % 4);
      PCSrc_e  = ($urandom % 25) == 0;
      PCTarget_e = $urandom & 32'hFFFF_FFFC;
      if (PCSrc_e) Flush_d = 1'b1;
      tick();
    end
    Stall_d = 1'b0; Flush_d = 1'b0; PCSrc_e = 1'b0; lat = 1;
  endtask

  task automatic test_async_reset();
    int found;
    imem_gnt = 1'b1; lat = 1;
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    n_chk += 5;
    if (Valid_d !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", Valid_d); end
    if (Instr_d !== NOP) begin n_fail++; $display("FAIL async_instr: got %h want %h", Instr_d, NOP); end
    if (PC_d !== 32'h0) begin n_fail++; $display("FAIL async_pc: got %h want 0", PC_d); end
    if (PCPlus4_d !== 32'h0) begin n_fail++; $display("FAIL async_pc4: got %h want 0", PCPlus4_d); end
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL async_req: got %b want 0", imem_req); end
    imem_rvalid = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (Valid_d === 1'b1) found = 1;
    end
    n_chk++;
    if (!found || PC_d !== 32'h0) begin n_fail++; $display("FAIL restart_pc: got %b/%h want 1/00000000", Valid_d, PC_d); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect();
    test_gnt_hold();
    test_flush_stall();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
